// File: rtl/qos_vc_arbiter.sv
`default_nettype none
// ============================================================================
// qos_vc_arbiter : burst-limited class-FIFO arbiter feeding one egress FIFO.
// Macro QOS_ARB_RR_EN selects round-robin, else fixed priority.  Rev 1.0
// ============================================================================
module qos_vc_arbiter #(
   parameter int BW     = 6,
   parameter int NUM_VC = 4,
   parameter int BURST  = 2
) (
   input  logic                 clk,
   input  logic                 reset_L,
   input  logic [NUM_VC-1:0]    vc_empty,
   input  logic [NUM_VC*BW-1:0] vc_data,
   output logic [NUM_VC-1:0]    vc_pop,
   input  logic                 egr_almost_full,
   output logic                 egr_push,
   output logic [BW-1:0]        egr_data,
   output logic [2:0]           egr_vc,
   output logic [1:0]           state_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE   = 2'd1,
      HOLD    = 2'd2,
      ILLEGAL = 2'd3
   } state_t;

   localparam logic [3:0] BURST_C = 4'(BURST);
   localparam logic [2:0] LAST_VC = 3'(NUM_VC - 1);

   state_t              state;
   logic [3:0]          burst_cnt;
   logic [2:0]          prev_vc;
`ifdef QOS_ARB_RR_EN
   logic [2:0]          ptr;
`endif

   logic [NUM_VC-1:0]   req, prev_oh, mask, cand, grant;
   logic [2:0]          grant_idx;
   logic                grant_vld, allow;
   logic [BW-1:0]       sel_data;

   assign req   = ~vc_empty;
   assign allow = (state != HOLD) && !egr_almost_full && (req != '0);

   always_comb begin
      prev_oh = '0;
      for (int i = 0; i < NUM_VC; i++)
         prev_oh[i] = (prev_vc == 3'(i));
   end

   // The class that hit its burst yields only if someone else is waiting.
   always_comb begin
      mask = '0;
      if (burst_cnt >= BURST_C && (req & ~prev_oh) != '0)
         mask = prev_oh;
   end

   always_comb begin
`ifdef QOS_ARB_RR_EN
      int idx;
      idx = 0;
`endif
      cand      = req & ~mask;
      grant_idx = '0;
      grant_vld = 1'b0;
`ifdef QOS_ARB_RR_EN
      for (int k = 1; k <= NUM_VC; k++) begin
         idx = (int'(ptr) + k) % NUM_VC;
         for (int i = 0; i < NUM_VC; i++) begin
            if (!grant_vld && i == idx && cand[i]) begin
               grant_vld = 1'b1;
               grant_idx = 3'(i);
            end
         end
      end
`else
      for (int i = 0; i < NUM_VC; i++) begin
         if (!grant_vld && cand[i]) begin
            grant_vld = 1'b1;
            grant_idx = 3'(i);
         end
      end
`endif
      if (!allow)
         grant_vld = 1'b0;
   end

   always_comb begin
      grant    = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_VC; i++) begin
         grant[i] = grant_vld && (grant_idx == 3'(i));
         if (grant[i])
            sel_data = vc_data[i*BW +: BW];
      end
   end

   assign vc_pop  = reset_L ? grant : '0;
   assign state_o = state;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state     <= IDLE;
         egr_push  <= 1'b0;
         egr_data  <= '0;
         egr_vc    <= '0;
         burst_cnt <= '0;
         prev_vc   <= LAST_VC;
`ifdef QOS_ARB_RR_EN
         ptr       <= LAST_VC;
`endif
      end else begin
         egr_push <= grant_vld;
         if (grant_vld) begin
            egr_data  <= sel_data;
            egr_vc    <= grant_idx;
            burst_cnt <= (grant_idx != prev_vc) ? 4'd1 :
                         (burst_cnt >= BURST_C) ? BURST_C : burst_cnt + 4'd1;
            prev_vc   <= grant_idx;
`ifdef QOS_ARB_RR_EN
            ptr       <= grant_idx;
`endif
         end
         case (state)
            IDLE: begin
               if (egr_almost_full)  state <= HOLD;
               else if (req != '0)   state <= SERVE;
            end
            SERVE: begin
               if (egr_almost_full)  state <= HOLD;
               else if (req == '0)   state <= IDLE;
            end
            HOLD: begin
               if (!egr_almost_full) state <= (req != '0) ? SERVE : IDLE;
            end
            default:                 state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_qos_vc_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// tb_qos_vc_arbiter : randomized and directed checks against a queue-based model.
module tb_qos_vc_arbiter;

   localparam int BW     = 6;
   localparam int NUM_VC = 4;
   localparam int BURST  = 2;
   localparam int DEPTH  = 512;

   logic                 clk = 1'b0;
   logic                 reset_L = 1'b0;
   logic [NUM_VC-1:0]    vc_empty = '1;
   logic [NUM_VC*BW-1:0] vc_data = '0;
   logic [NUM_VC-1:0]    vc_pop;
   logic                 egr_almost_full = 1'b0;
   logic                 egr_push;
   logic [BW-1:0]        egr_data;
   logic [2:0]           egr_vc;
   logic [1:0]           state_o;

   always #5 clk = ~clk;

   qos_vc_arbiter #(.BW(BW), .NUM_VC(NUM_VC), .BURST(BURST)) dut (
      .clk(clk), .reset_L(reset_L), .vc_empty(vc_empty), .vc_data(vc_data),
      .vc_pop(vc_pop), .egr_almost_full(egr_almost_full), .egr_push(egr_push),
      .egr_data(egr_data), .egr_vc(egr_vc), .state_o(state_o));

   int checks = 0;
   int fails  = 0;

   // Class FIFO contents as seen by the arbiter
   logic [BW-1:0] mem [NUM_VC][DEPTH];
   int head [NUM_VC];
   int tail [NUM_VC];
   bit af = 1'b0;

   // Reference model: 0=IDLE 1=SERVE 2=HOLD
   int            m_state, m_cnt, m_prev, m_ptr, m_vc;
   bit            m_push;
   logic [BW-1:0] m_data;
   int            pushes, pops;

   function automatic bit nonempty(int i);
      return head[i] != tail[i];
   endfunction

   function automatic bit any_req();
      bit a = 1'b0;
      for (int i = 0; i < NUM_VC; i++) a |= nonempty(i);
      return a;
   endfunction

   function automatic int model_grant();
      int others = 0;
      int i;
      if (m_state == 2 || af || !any_req()) return -1;
      for (int j = 0; j < NUM_VC; j++)
         if (j != m_prev && nonempty(j)) others++;
      for (int k = 0; k < NUM_VC; k++) begin
`ifdef QOS_ARB_RR_EN
         i = (m_ptr + 1 + k) % NUM_VC;
`else
         i = k;
`endif
         if (nonempty(i) && !(m_cnt >= BURST && i == m_prev && others > 0))
            return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_prev = -1; m_ptr = NUM_VC - 1;
      m_push = 1'b0; m_data = '0; m_vc = 0;
   endtask

   task automatic clear_fifos();
      for (int i = 0; i < NUM_VC; i++) begin head[i] = 0; tail[i] = 0; end
   endtask

   task automatic load(int c, logic [BW-1:0] w);
      if (tail[c] < DEPTH) begin
         mem[c][tail[c]] = w;
         tail[c]++;
      end
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < NUM_VC; i++) begin
         vc_empty[i] = !nonempty(i);
         vc_data[i*BW +: BW] = nonempty(i) ? mem[i][head[i]] : '0;
      end
      egr_almost_full = af;
   endtask

   // One clock cycle: drive, check combinational and registered outputs, advance.
   task automatic step(output int g_obs);
      int g;
      bit req_any;
      logic [NUM_VC-1:0] exp_pop;
      drive_inputs();
      #1;
      g = model_grant();
      exp_pop = (g >= 0) ? (NUM_VC'(1) << g) : '0;
      checks++;
      if (vc_pop !== exp_pop) begin
         fails++;
         $display("FAIL vc_pop at %0t: got %b expected %b", $time, vc_pop, exp_pop);
      end
      checks++;
      if (egr_push !== m_push) begin
         fails++;
         $display("FAIL egr_push at %0t: got %b expected %b", $time, egr_push, m_push);
      end
      if (m_push) begin
         checks++;
         if (egr_data !== m_data || egr_vc !== 3'(m_vc)) begin
            fails++;
            $display("FAIL egr_word at %0t: got data %h vc %0d expected data %h vc %0d",
                     $time, egr_data, egr_vc, m_data, m_vc);
         end
      end
      checks++;
      if (state_o !== 2'(m_state)) begin
         fails++;
         $display("FAIL state_o at %0t: got %0d expected %0d", $time, state_o, m_state);
      end
      g_obs = -1;
      for (int i = 0; i < NUM_VC; i++) if (vc_pop[i] === 1'b1) g_obs = i;
      if (egr_push === 1'b1) pushes++;
      @(posedge clk);
      req_any = any_req();
      case (m_state)
         0: m_state = af ? 2 : (req_any ? 1 : 0);
         1: m_state = af ? 2 : (req_any ? 1 : 0);
         default: m_state = af ? 2 : (req_any ? 1 : 0);
      endcase
      m_push = (g >= 0);
      if (g >= 0) begin
         m_data = mem[g][head[g]];
         m_vc   = g;
         m_cnt  = (g == m_prev) ? ((m_cnt + 1 > BURST) ? BURST : m_cnt + 1) : 1;
         m_prev = g;
`ifdef QOS_ARB_RR_EN
         m_ptr  = g;
`endif
      end
      if (g_obs >= 0) begin
         pops++;
         if (nonempty(g_obs)) head[g_obs]++;
      end
      #1;
   endtask

   task automatic do_reset();
      reset_L = 1'b0;
      af = 1'b0;
      clear_fifos();
      drive_inputs();
      #1;
      checks++;
      if (vc_pop !== '0 || egr_push !== 1'b0 || egr_data !== '0 || egr_vc !== '0 || state_o !== 2'd0) begin
         fails++;
         $display("FAIL reset_values: got pop %b push %b data %h vc %0d state %0d expected all zero",
                  vc_pop, egr_push, egr_data, egr_vc, state_o);
      end
      @(posedge clk);
      #1;
      reset_L = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_single_class();
      int g;
      int exp_g [5] = '{2, 2, 2, -1, -1};
      clear_fifos();
      af = 1'b0;
      load(2, 6'h0A); load(2, 6'h1B); load(2, 6'h2C);
      for (int s = 0; s < 5; s++) begin
         step(g);
         checks++;
         if (g !== exp_g[s]) begin
            fails++;
            $display("FAIL single_class grant %0d: got %0d expected %0d", s, g, exp_g[s]);
         end
      end
   endtask

   task automatic test_burst();
      int g;
`ifdef QOS_ARB_RR_EN
      int exp_g [6] = '{0, 3, 0, 3, 0, 3};
`else
      int exp_g [6] = '{0, 0, 3, 0, 0, 3};
`endif
      do_reset();
      for (int w = 0; w < 8; w++) begin
         load(0, 6'($urandom)); load(3, 6'($urandom));
      end
      for (int s = 0; s < 6; s++) begin
         step(g);
         checks++;
         if (g !== exp_g[s]) begin
            fails++;
            $display("FAIL burst grant %0d: got %0d expected %0d", s, g, exp_g[s]);
         end
      end
      clear_fifos();
      step(g); step(g);
   endtask

   task automatic test_round_robin();
      int g;
`ifdef QOS_ARB_RR_EN
      int exp_g [5] = '{0, 1, 2, 3, 0};
`else
      int exp_g [5] = '{0, 0, 1, 0, 0};
`endif
      do_reset();
      for (int c = 0; c < NUM_VC; c++)
         for (int w = 0; w < 6; w++) load(c, 6'($urandom));
      for (int s = 0; s < 5; s++) begin
         step(g);
         checks++;
         if (g !== exp_g[s]) begin
            fails++;
            $display("FAIL arb_order grant %0d: got %0d expected %0d", s, g, exp_g[s]);
         end
      end
      clear_fifos();
      step(g); step(g);
   endtask

   task automatic test_backpressure();
      int g;
      do_reset();
      pushes = 0; pops = 0;
      for (int w = 0; w < 10; w++) begin
         load(0, 6'($urandom)); load(1, 6'($urandom));
      end
      for (int s = 0; s < 3; s++) step(g);
      af = 1'b1;
      for (int s = 0; s < 5; s++) begin
         step(g);
         checks++;
         if (g !== -1) begin
            fails++;
            $display("FAIL stall_pop %0d: got grant %0d expected none", s, g);
         end
      end
      af = 1'b0;
      for (int s = 0; s < 25; s++) step(g);
      checks++;
      if (pops !== 20 || pushes !== 20) begin
         fails++;
         $display("FAIL backpressure_count: got pops %0d pushes %0d expected 20 and 20", pops, pushes);
      end
   endtask

   task automatic test_all_empty();
      int g;
      clear_fifos();
      af = 1'b0;
      for (int s = 0; s < 10; s++) begin
         step(g);
         checks++;
         if (g !== -1 || egr_push !== 1'b0) begin
            fails++;
            $display("FAIL all_empty %0d: got grant %0d push %b expected none", s, g, egr_push);
         end
      end
   endtask

   task automatic test_reset_midstream();
      int g;
      clear_fifos();
      af = 1'b0;
      for (int w = 0; w < 4; w++) load(1, 6'($urandom_range(1, 63)));
      step(g); step(g);
      reset_L = 1'b0;
      #1;
      checks++;
      if (vc_pop !== '0 || egr_push !== 1'b0 || egr_data !== '0 || state_o !== 2'd0) begin
         fails++;
         $display("FAIL midstream_reset: got pop %b push %b data %h state %0d expected all zero",
                  vc_pop, egr_push, egr_data, state_o);
      end
      @(posedge clk);
      #1;
      reset_L = 1'b1;
      model_reset();
      clear_fifos();
      for (int s = 0; s < 3; s++) begin
         step(g);
         checks++;
         if (egr_push !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_push %0d: got %b expected 0", s, egr_push);
         end
      end
   endtask

   task automatic test_random();
      int g;
      clear_fifos();
      for (int s = 0; s < 400; s++) begin
         for (int c = 0; c < NUM_VC; c++)
            if ($urandom_range(0, 3) == 0) load(c, 6'($urandom));
         af = ($urandom_range(0, 4) == 0);
         step(g);
      end
      af = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_class();
      test_burst();
      test_round_robin();
      test_backpressure();
      test_all_empty();
      test_reset_midstream();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
